// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared definitions for the iterative multiply/divide unit.
//   op_e    : operation encodings driven on op (MULT/MULTU/DIV/DIVU)
//   state_e : sequencer states
//   CNT_W   : step counter width; LAST_STEP is the final CALC step index
package muldiv_pkg;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        FIX  = 2'b10
    } state_e;

    localparam int unsigned       CNT_W     = 5;
    localparam logic [CNT_W-1:0]  LAST_STEP = CNT_W'(31);

endpackage

// File: rtl/muldiv_unit_if.sv
// muldiv_unit_if: request/result bundle between pipeline control and muldiv_unit.
//   master (control/datapath side): drives start, op, a, b, hi_we, lo_we, wd;
//                                   observes busy, done, hi, lo
//   slave  (muldiv_unit)          : the reverse
interface muldiv_unit_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             hi_we;
    logic             lo_we;
    logic [WIDTH-1:0] wd;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, a, b, hi_we, lo_we, wd,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, a, b, hi_we, lo_we, wd,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative radix-2 multiply/divide unit with HI/LO registers.
//   clk, rst : clock (rising edge), asynchronous active-high reset
//   bus      : muldiv_unit_if.slave
//     start/op/a/b : launch MULT/MULTU/DIV/DIVU (sampled only when idle)
//     hi_we/lo_we/wd : MTHI/MTLO writes (honoured only when idle and no start)
//     busy/done    : operation in progress / one-cycle result-ready pulse
//     hi/lo        : architectural HI/LO registers
// Latency: start sampled at E0, 32 CALC steps at E1..E32, signs applied and
// HI/LO written at E33. All outputs come straight from flops.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic          clk,
    input  logic          rst,
    muldiv_unit_if.slave  bus
);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               is_div_q, is_div_d;
    logic               is_signed_q, is_signed_d;
    logic               neg_q, neg_d;       // operand signs differ
    logic               sa_q, sa_d;         // sign of dividend
    logic               bzero_q, bzero_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;     // multiplicand or divisor magnitude
    logic [2*WIDTH-1:0] acc_q, acc_d;       // {upper, lower} working register
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               done_q, done_d;

    // Operand conditioning at launch
    logic               a_neg, b_neg;
    logic [WIDTH-1:0]   mag_a, mag_b;

    assign a_neg = ~bus.op[0] & bus.a[WIDTH-1];
    assign b_neg = ~bus.op[0] & bus.b[WIDTH-1];
    assign mag_a = a_neg ? -bus.a : bus.a;
    assign mag_b = b_neg ? -bus.b : bus.b;

    // Shared adder: multiply adds the multiplicand to the upper half when the
    // multiplier LSB is set; divide subtracts the divisor from the upper half
    // shifted left by one (33-bit partial remainder), sign bit = borrow.
    logic [WIDTH+1:0]   add_a, add_b, sum;
    logic               add_cin;

    always_comb begin
        if (is_div_q) begin
            add_a   = {1'b0, acc_q[2*WIDTH-1:WIDTH-1]};
            add_b   = ~{2'b00, opnd_q};
            add_cin = 1'b1;
        end else begin
            add_a   = {2'b00, acc_q[2*WIDTH-1:WIDTH]};
            add_b   = acc_q[0] ? {2'b00, opnd_q} : '0;
            add_cin = 1'b0;
        end
        sum = add_a + add_b + {{(WIDTH+1){1'b0}}, add_cin};
    end

    // Sign fix-up of the finished magnitudes
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quo, rem;

    always_comb begin
        prod = (is_signed_q && neg_q) ? -acc_q : acc_q;
        quo  = (is_signed_q && neg_q) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        rem  = (is_signed_q && sa_q) ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
        if (bzero_q) begin
            quo = '1;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        is_div_d    = is_div_q;
        is_signed_d = is_signed_q;
        neg_d       = neg_q;
        sa_d        = sa_q;
        bzero_d     = bzero_q;
        opnd_d      = opnd_q;
        acc_d       = acc_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        done_d      = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d     = CALC;
                    cnt_d       = '0;
                    is_div_d    = bus.op[1];
                    is_signed_d = ~bus.op[0];
                    sa_d        = a_neg;
                    neg_d       = a_neg ^ b_neg;
                    bzero_d     = (bus.b == '0);
                    opnd_d      = mag_b;
                    // Multiplier and dividend both start in the lower half
                    acc_d       = {{WIDTH{1'b0}}, mag_a};
                end else begin
                    if (bus.hi_we) hi_d = bus.wd;
                    if (bus.lo_we) lo_d = bus.wd;
                end
            end
            CALC: begin
                if (is_div_q) begin
                    if (!sum[WIDTH+1]) begin
                        acc_d = {sum[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
                    end else begin
                        acc_d = {acc_q[2*WIDTH-2:0], 1'b0};
                    end
                end else begin
                    acc_d = {sum[WIDTH:0], acc_q[WIDTH-1:1]};
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_STEP) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                if (is_div_q) begin
                    hi_d = rem;
                    lo_d = quo;
                end else begin
                    hi_d = prod[2*WIDTH-1:WIDTH];
                    lo_d = prod[WIDTH-1:0];
                end
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            is_div_q    <= 1'b0;
            is_signed_q <= 1'b0;
            neg_q       <= 1'b0;
            sa_q        <= 1'b0;
            bzero_q     <= 1'b0;
            opnd_q      <= '0;
            acc_q       <= '0;
            hi_q        <= '0;
            lo_q        <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            is_div_q    <= is_div_d;
            is_signed_q <= is_signed_d;
            neg_q       <= neg_d;
            sa_q        <= sa_d;
            bzero_q     <= bzero_d;
            opnd_q      <= opnd_d;
            acc_q       <= acc_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            done_q      <= done_d;
        end
    end

    assign bus.busy = (state_q != IDLE);
    assign bus.done = done_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;

endmodule
